// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage RV32I core: load-use stalls, EX branch flushes, dmem waits.
// Enables/flush are combinational from state+inputs; optional perf counters under `ifdef PERF_CNT_EN.
module hazard_ctrl #(
   parameter int LOAD_STALL_CYC = 1,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       id_op,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [6:0]       idex_op,
   input  logic [4:0]       idex_rd,
   input  logic             ex_take,
   input  logic             dmem_busy,
   output logic             ena_pc,
   output logic             pc_sel,
   output logic             ena_ifid,
   output logic             flush_ifid,
   output logic             ena_idex,
   output logic             bubble_idex,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [2:0] LU_INIT   = 3'(LOAD_STALL_CYC - 1);

   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

   state_t     state_q, state_d;
   state_t     saved_q, saved_d;
   logic [2:0] lu_cnt_q, lu_cnt_d;
   state_t     eff_st;

   logic uses_rs1, uses_rs2, hu;
   logic ena_pc_c, pc_sel_c, ena_ifid_c, flush_c, ena_idex_c, bubble_c;

   assign uses_rs1 = (id_op == OP_OP) || (id_op == OP_OPIMM) || (id_op == OP_LOAD) ||
                     (id_op == OP_STORE) || (id_op == OP_BRANCH) || (id_op == OP_JALR);
   assign uses_rs2 = (id_op == OP_OP) || (id_op == OP_STORE) || (id_op == OP_BRANCH);
   assign hu = (idex_op == OP_LOAD) && (idex_rd != 5'd0) &&
               (((idex_rd == id_rs1) && uses_rs1) || ((idex_rd == id_rs2) && uses_rs2));

   // MEM_WAIT is only a hold: once busy drops, act as the state it interrupted.
   assign eff_st = (state_q == MEM_WAIT) ? saved_q : state_q;

   always_comb begin
      ena_pc_c   = 1'b0;
      pc_sel_c   = 1'b0;
      ena_ifid_c = 1'b0;
      flush_c    = 1'b0;
      ena_idex_c = 1'b0;
      bubble_c   = 1'b0;
      state_d    = state_q;
      saved_d    = saved_q;
      lu_cnt_d   = lu_cnt_q;
      if (dmem_busy) begin
         state_d = MEM_WAIT;
         if (state_q != MEM_WAIT) saved_d = state_q;
      end else if (ex_take) begin
         ena_pc_c   = 1'b1;
         pc_sel_c   = 1'b1;
         ena_ifid_c = 1'b1;
         flush_c    = 1'b1;
         ena_idex_c = 1'b1;
         bubble_c   = 1'b1;
         state_d    = RUN;
         lu_cnt_d   = 3'd0;
      end else if (eff_st == LU_STALL) begin
         ena_idex_c = 1'b1;
         bubble_c   = 1'b1;
         lu_cnt_d   = lu_cnt_q - 3'd1;
         state_d    = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
      end else if (hu) begin
         ena_idex_c = 1'b1;
         bubble_c   = 1'b1;
         if (LOAD_STALL_CYC > 1) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_INIT;
         end else begin
            state_d  = RUN;
         end
      end else begin
         ena_pc_c   = 1'b1;
         ena_ifid_c = 1'b1;
         ena_idex_c = 1'b1;
         state_d    = RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         saved_q  <= RUN;
         lu_cnt_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         saved_q  <= saved_d;
         lu_cnt_q <= lu_cnt_d;
      end
   end

   assign ena_pc      = !rst && ena_pc_c;
   assign pc_sel      = !rst && pc_sel_c;
   assign ena_ifid    = !rst && ena_ifid_c;
   assign flush_ifid  = !rst && flush_c;
   assign ena_idex    = !rst && ena_idex_c;
   assign bubble_idex = !rst && bubble_c;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!ena_pc_c) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_c)   flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded random bench for hazard_ctrl: two instances (LOAD_STALL_CYC 1 and 3) against a bubble-count model.
module tb_hazard_ctrl;
   localparam int CW = 8;

   typedef struct packed {
      logic          ena_pc, pc_sel, ena_ifid, flush_ifid, ena_idex, bubble_idex;
      logic [CW-1:0] stall, flush;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] id_op = '0, idex_op = '0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
   logic       ex_take = 1'b0, dmem_busy = 1'b0;

   logic          a_pc, a_sel, a_ifid, a_fl, a_idex, a_bub;
   logic          b_pc, b_sel, b_ifid, b_fl, b_idex, b_bub;
   logic [CW-1:0] a_sc, a_fc, b_sc, b_fc;

   hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(CW)) u_n1 (
      .clk(clk), .rst(rst), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .idex_op(idex_op), .idex_rd(idex_rd), .ex_take(ex_take), .dmem_busy(dmem_busy),
      .ena_pc(a_pc), .pc_sel(a_sel), .ena_ifid(a_ifid), .flush_ifid(a_fl),
      .ena_idex(a_idex), .bubble_idex(a_bub), .stall_cnt(a_sc), .flush_cnt(a_fc));

   hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(CW)) u_n3 (
      .clk(clk), .rst(rst), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .idex_op(idex_op), .idex_rd(idex_rd), .ex_take(ex_take), .dmem_busy(dmem_busy),
      .ena_pc(b_pc), .pc_sel(b_sel), .ena_ifid(b_ifid), .flush_ifid(b_fl),
      .ena_idex(b_idex), .bubble_idex(b_bub), .stall_cnt(b_sc), .flush_cnt(b_fc));

   always #5 clk = ~clk;

   exp_t q1[$];
   exp_t q3[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // model state: bubbles still owed, and free-running stall/flush counts
   int rem[2]   = '{0, 0};
   int scnt[2]  = '{0, 0};
   int fcnt[2]  = '{0, 0};
   int nstall[2] = '{1, 3};

   function automatic bit reads_rs1(input logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
             op == 7'b0100011 || op == 7'b1100011 || op == 7'b1100111;
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
   endfunction

   function automatic exp_t model_step(input int k, input bit hz);
      exp_t e;
      e = '0;
      if (rst) begin
         rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
         return e;
      end
`ifdef PERF_CNT_EN
      e.stall = CW'(scnt[k] % 256);
      e.flush = CW'(fcnt[k] % 256);
`endif
      if (dmem_busy) begin
         scnt[k]++;
      end else if (ex_take) begin
         {e.ena_pc, e.pc_sel, e.ena_ifid, e.flush_ifid, e.ena_idex, e.bubble_idex} = 6'b111111;
         rem[k] = 0;
         fcnt[k]++;
      end else if (rem[k] > 0 || hz) begin
         e.ena_idex = 1'b1; e.bubble_idex = 1'b1;
         rem[k] = (rem[k] > 0) ? rem[k] - 1 : nstall[k] - 1;
         scnt[k]++;
      end else begin
         e.ena_pc = 1'b1; e.ena_ifid = 1'b1; e.ena_idex = 1'b1;
      end
      return e;
   endfunction

   task automatic drive(input bit r, input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [6:0] iop, input logic [4:0] ird, input bit tk, input bit bz);
      bit hz;
      @(negedge clk);
      rst = r; id_op = op; id_rs1 = s1; id_rs2 = s2;
      idex_op = iop; idex_rd = ird; ex_take = tk; dmem_busy = bz;
      hz = (iop == 7'b0000011) && (ird != 0) &&
           ((ird == s1 && reads_rs1(op)) || (ird == s2 && reads_rs2(op)));
      q1.push_back(model_step(0, hz));
      q3.push_back(model_step(1, hz));
   endtask

   always @(negedge clk) begin
      exp_t e, g;
      #2;
      cyc++;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         g = {a_pc, a_sel, a_ifid, a_fl, a_idex, a_bub, a_sc, a_fc};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL n1_outputs cyc=%0d got=%h exp=%h", cyc, g, e);
         end
      end
      if (q3.size() > 0) begin
         e = q3.pop_front();
         g = {b_pc, b_sel, b_ifid, b_fl, b_idex, b_bub, b_sc, b_fc};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL n3_outputs cyc=%0d got=%h exp=%h", cyc, g, e);
         end
      end
   end

   localparam logic [6:0] LD = 7'b0000011, RR = 7'b0110011, LUI = 7'b0110111, BUB = 7'b0000000;

   initial begin
      logic [6:0] ops [8];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};
      // reset state
      drive(1, RR, 1, 5, LD, 5, 0, 0);
      drive(1, RR, 1, 5, LD, 5, 0, 0);
      // basic load-use, then bubble in ID/EX
      drive(0, RR, 1, 5, LD, 5, 0, 0);
      repeat (3) drive(0, RR, 1, 5, BUB, 0, 0, 0);
      // no hazard: x0 destination, and LUI ignores rs1
      drive(0, RR, 1, 0, LD, 0, 0, 0);
      drive(0, LUI, 5, 0, LD, 5, 0, 0);
      // branch coincident with hazard
      drive(0, RR, 1, 5, LD, 5, 1, 0);
      drive(0, RR, 1, 2, BUB, 0, 0, 0);
      // branch during an in-progress stall
      drive(0, RR, 5, 2, LD, 5, 0, 0);
      drive(0, RR, 5, 2, BUB, 0, 1, 0);
      drive(0, RR, 5, 2, BUB, 0, 0, 0);
      // memory wait in the middle of a multi-cycle stall
      drive(0, RR, 5, 2, LD, 5, 0, 0);
      repeat (4) drive(0, RR, 5, 2, BUB, 0, 0, 1);
      repeat (3) drive(0, RR, 5, 2, BUB, 0, 0, 0);
      // async reset mid-stall
      drive(0, RR, 5, 2, LD, 5, 0, 0);
      drive(1, RR, 5, 2, BUB, 0, 0, 0);
      repeat (2) drive(0, RR, 5, 2, BUB, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 199) == 0,
               ops[$urandom_range(0, 7)],
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0) ? 7'($urandom) : LD,
               5'($urandom_range(0, 3)),
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 6) == 0);
      end
      repeat (3) @(negedge clk);
      #4;
      checks++;
      if (q1.size() != 0 || q3.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d required=0", q1.size() + q3.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
